// File: rtl/mac_mul_pipe_if.sv
// -----------------------------------------------------------------------------
// mac_mul_pipe_if
// Beat-level bus of the MAC multiply front end.
//   cfg       lane chaining select travelling with the beat
//   A, B      multi-lane operand and common multiplicand
//   in_valid  upstream beat valid          in_ready  block accepts the beat
//   C, err    product and reserved-cfg flag
//   out_valid C/err valid                  out_ready downstream accepts C
// The master modport is the traffic source/sink around the block; the slave
// modport is the multiplier itself.
// -----------------------------------------------------------------------------
interface mac_mul_pipe_if #(
    parameter int W     = 8,
    parameter int LANES = 4,
    parameter int CFG_W = 2
);
    logic [CFG_W-1:0]       cfg;
    logic [LANES*W-1:0]     A;
    logic [W-1:0]           B;
    logic                   in_valid;
    logic                   in_ready;
    logic [(LANES+1)*W-1:0] C;
    logic                   err;
    logic                   out_valid;
    logic                   out_ready;

    modport master (
        output cfg, A, B, in_valid, out_ready,
        input  in_ready, C, err, out_valid
    );

    modport slave (
        input  cfg, A, B, in_valid, out_ready,
        output in_ready, C, err, out_valid
    );
endinterface

// File: rtl/mac_mul_pipe.sv
// -----------------------------------------------------------------------------
// mac_mul_pipe
// Two-stage pipelined multiply front end for the MAC datapath. Computes
// C = sum(A_i * B << i*W) over the 2^cfg active lanes of A.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous, active-low reset
//   en    block enable; 0 freezes every pipeline register
//   bus   beat bus (slave side): cfg/A/B/in_valid in, in_ready out,
//         C/err/out_valid out, out_ready in
// Stage 1 registers the per-lane partial products, stage 2 registers the
// shifted sum. Both stages advance together on adv, so a stall holds the
// entire pipeline, bubbles included.
// -----------------------------------------------------------------------------
module mac_mul_pipe #(
    parameter int W     = 8,
    parameter int LANES = 4,
    parameter int CFG_W = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    mac_mul_pipe_if.slave      bus
);

    localparam int CW = (LANES + 1) * W;
    localparam int PW = 2 * W;

    logic          adv_s;
    logic [31:0]   lane_cnt_s;
    logic          reserved_s;
    logic [PW-1:0] p_next_s [LANES];
    logic [CW-1:0] sum_s;

    logic [PW-1:0] p_r [LANES];
    logic          err1_r;
    logic          s1_valid_r;
    logic          s2_valid_r;
    logic          err_r;
    logic [CW-1:0] c_r;

    // A single advance strobe moves both stages; the output slot frees up
    // either when it is empty or when downstream takes it this cycle.
    assign adv_s        = en & (~s2_valid_r | bus.out_ready);
    assign bus.in_ready = adv_s;

    // Decode active lane count; a cfg asking for more lanes than exist is reserved.
    always_comb begin
        lane_cnt_s = 32'd1 << bus.cfg;
        if (lane_cnt_s > 32'(LANES)) begin
            reserved_s = 1'b1;
        end else begin
            reserved_s = 1'b0;
        end
    end

    // Per-lane partial products; inactive lanes and reserved beats contribute zero.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            if (!reserved_s && (32'(i) < lane_cnt_s)) begin
                p_next_s[i] = PW'(bus.A[i*W +: W]) * PW'(bus.B);
            end else begin
                p_next_s[i] = '0;
            end
        end
    end

    // Stage 1: capture partial products, reserved flag and beat valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LANES; i++) begin
                p_r[i] <= '0;
            end
            err1_r     <= 1'b0;
            s1_valid_r <= 1'b0;
        end else if (adv_s) begin
            for (int i = 0; i < LANES; i++) begin
                p_r[i] <= p_next_s[i];
            end
            err1_r     <= reserved_s;
            s1_valid_r <= bus.in_valid;
        end
    end

    // Recombine lanes: lane i carries weight 2^(i*W); the sum cannot exceed CW bits.
    always_comb begin
        sum_s = '0;
        for (int i = 0; i < LANES; i++) begin
            sum_s = sum_s + (CW'(p_r[i]) << (i * W));
        end
    end

    // Stage 2: output register; a bubble only clears out_valid, C/err keep the last beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_valid_r <= 1'b0;
            c_r        <= '0;
            err_r      <= 1'b0;
        end else if (adv_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                c_r   <= sum_s;
                err_r <= err1_r;
            end
        end
    end

    assign bus.C         = c_r;
    assign bus.err       = err_r;
    assign bus.out_valid = s2_valid_r;

endmodule
